// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 codes, access
// size and FSM state enums, and the funct3 decoder.
package mem_pkg;

  localparam logic [2:0] MEM_F3_BYTE   = 3'b000;
  localparam logic [2:0] MEM_F3_HALF   = 3'b001;
  localparam logic [2:0] MEM_F3_WORD   = 3'b010;
  localparam logic [2:0] MEM_F3_DWORD  = 3'b011;
  localparam logic [2:0] MEM_F3_BYTE_U = 3'b100;
  localparam logic [2:0] MEM_F3_HALF_U = 3'b101;
  localparam logic [2:0] MEM_F3_WORD_U = 3'b110;

  typedef enum logic [1:0] {
    B = 2'd0,
    H = 2'd1,
    W = 2'd2,
    D = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic      legal;
    mem_size_t size;
    logic      sign;
  } mem_dec_t;

  // Map store flag + funct3 to size/sign; doubleword forms and LWU exist only on RV64.
  function automatic mem_dec_t mem_decode(input logic store, input logic [2:0] funct3,
                                          input logic rv64);
    mem_dec_t d;
    d.legal = 1'b0;
    d.size  = B;
    d.sign  = 1'b0;
    if (store) begin
      case (funct3)
        MEM_F3_BYTE:  begin d.legal = 1'b1; d.size = B; end
        MEM_F3_HALF:  begin d.legal = 1'b1; d.size = H; end
        MEM_F3_WORD:  begin d.legal = 1'b1; d.size = W; end
        MEM_F3_DWORD: begin d.legal = rv64; d.size = D; end
        default: ;
      endcase
    end else begin
      case (funct3)
        MEM_F3_BYTE:   begin d.legal = 1'b1; d.size = B; d.sign = 1'b1; end
        MEM_F3_HALF:   begin d.legal = 1'b1; d.size = H; d.sign = 1'b1; end
        MEM_F3_WORD:   begin d.legal = 1'b1; d.size = W; d.sign = 1'b1; end
        MEM_F3_DWORD:  begin d.legal = rv64; d.size = D; d.sign = 1'b1; end
        MEM_F3_BYTE_U: begin d.legal = 1'b1; d.size = B; end
        MEM_F3_HALF_U: begin d.legal = 1'b1; d.size = H; end
        MEM_F3_WORD_U: begin d.legal = rv64; d.size = W; end
        default: ;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Combinational lane steering for one access: byte strobes, store-data shift,
// load-data shift/extension and the misalignment flag.
// MEM_MISALIGN_TRAP_EN: when defined, misaligned offsets raise the flag;
// otherwise the offset is silently rounded down to the access size.
module mem_align
  import mem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NB    = XLEN / 8,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  mem_size_t        size,
  input  logic             sign,
  input  logic [OFF_W-1:0] off,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata,
  output logic [NB-1:0]    strb,
  output logic [XLEN-1:0]  wdata_sh,
  output logic [XLEN-1:0]  rdata_ext,
  output logic             misaligned
);

  logic [OFF_W-1:0] low_mask;
  logic [OFF_W-1:0] off_al;
  logic [NB-1:0]    size_mask;
  logic [XLEN-1:0]  keep;
  logic [XLEN-1:0]  rd_sh;
  logic             top_bit;

  // Per-size offset bits that must be zero, byte mask and value mask.
  always_comb begin
    low_mask  = '0;
    size_mask = NB'(1);
    keep      = XLEN'(8'hFF);
    case (size)
      H: begin
        low_mask  = OFF_W'(1);
        size_mask = NB'(3);
        keep      = XLEN'(16'hFFFF);
      end
      W: begin
        low_mask  = OFF_W'(3);
        size_mask = NB'(4'hF);
        keep      = XLEN'(32'hFFFF_FFFF);
      end
      D: begin
        low_mask  = OFF_W'(7);
        size_mask = NB'(8'hFF);
        keep      = '1;
      end
      default: ;
    endcase
  end

  // Aligned accesses are unchanged; misaligned ones drop the sub-size offset bits.
  assign off_al   = off & ~low_mask;
  assign strb     = size_mask << off_al;
  assign wdata_sh = wdata << {off_al, 3'b000};
  assign rd_sh    = rdata >> {off_al, 3'b000};

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = |(off & low_mask);
`else
  assign misaligned = 1'b0;
`endif

  // Pick the sign bit of the access size out of the right-justified read data.
  always_comb begin
    top_bit = rd_sh[7];
    case (size)
      H:       top_bit = rd_sh[15];
      W:       top_bit = rd_sh[31];
      D:       top_bit = rd_sh[XLEN-1];
      default: top_bit = rd_sh[7];
    endcase
  end

  // Truncate to the access size, then fill the upper bits for signed loads.
  always_comb begin
    rdata_ext = rd_sh & keep;
    if (sign && top_bit) begin
      rdata_ext = rdata_ext | ~keep;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store execution unit: accepts one request, runs one bus transaction
// (or skips it on error) and returns extended load data.
// Build option MEM_MISALIGN_TRAP_EN (see mem_align) turns misaligned
// accesses into errors instead of rounding them down.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [XLEN/8-1:0]   bus_strb,
  output logic [XLEN-1:0]     bus_wdata,
  input  logic [XLEN-1:0]     bus_rdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_err
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  mem_state_t        state_reg, state_next;
  logic              store_reg, sign_reg, err_reg;
  mem_size_t         size_reg;
  logic [OFF_W-1:0]  off_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [NB-1:0]     strb_reg;
  logic [XLEN-1:0]   wdata_reg, rdata_reg;

  mem_dec_t          dec;
  logic              idle, accept, legal;
  mem_size_t         al_size;
  logic              al_sign, al_mis;
  logic [OFF_W-1:0]  al_off;
  logic [NB-1:0]     al_strb;
  logic [XLEN-1:0]   al_wdata, al_rdata;

  assign dec    = mem_decode(req_store, req_funct3, XLEN == 64);
  assign idle   = (state_reg == IDLE);
  assign accept = idle && req_valid;
  assign legal  = dec.legal && !al_mis;

  // One aligner serves both phases: in IDLE it sees the incoming request (strobes,
  // store data, alignment check); afterwards it sees the held access for load extension.
  assign al_size = idle ? dec.size : size_reg;
  assign al_sign = idle ? dec.sign : sign_reg;
  assign al_off  = idle ? req_addr[OFF_W-1:0] : off_reg;

  mem_align #(.XLEN(XLEN)) u_align (
    .size       (al_size),
    .sign       (al_sign),
    .off        (al_off),
    .wdata      (req_wdata),
    .rdata      (bus_rdata),
    .strb       (al_strb),
    .wdata_sh   (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_mis)
  );

  // State register; reset aborts any bus access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and handshake/bus outputs; bus and response fields read zero outside their phase.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    bus_valid  = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_strb   = '0;
    bus_wdata  = '0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = legal ? BUS : RESP;
        end
      end
      BUS: begin
        bus_valid = 1'b1;
        bus_we    = store_reg;
        bus_addr  = addr_reg;
        bus_strb  = strb_reg;
        bus_wdata = wdata_reg;
        if (bus_ready) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_reg;
        resp_err   = err_reg;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the request at acceptance and the load result at the bus handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_reg <= 1'b0;
      sign_reg  <= 1'b0;
      err_reg   <= 1'b0;
      size_reg  <= B;
      off_reg   <= '0;
      addr_reg  <= '0;
      strb_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else if (accept) begin
      store_reg <= req_store;
      sign_reg  <= dec.sign;
      err_reg   <= !legal;
      size_reg  <= dec.size;
      off_reg   <= req_addr[OFF_W-1:0];
      addr_reg  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      strb_reg  <= al_strb;
      wdata_reg <= al_wdata;
      rdata_reg <= '0;
    end else if (state_reg == BUS && bus_ready) begin
      rdata_reg <= store_reg ? '0 : al_rdata;
    end
  end

endmodule
